// File: rtl/peri_uart_pkg.sv
// Shared types and constants for the peri_uart_tx peripheral and its serializer core.
package peri_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } uart_state_e;

  localparam int unsigned CTRL_SEND_BIT        = 0;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1042;

endpackage

// File: rtl/peri_uart_tx_core.sv
// 8N1 serializer: FSM, baud counter and shift register. i_start is sampled while idle;
// o_done is high for the single DONE cycle after the stop bit.
module uart_tx_core
  import peri_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [DATA_BITS-1:0] i_byte,
  output logic                 o_done,
  output logic                 o_tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_done;
  logic                 w_tick;

  assign w_tick = (r_cnt == LAST_CNT);
  assign o_tx   = r_tx;
  assign o_done = r_done;

  // r_tx is loaded with the level of the state being entered so the line is registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (i_start) begin
            r_shift <= i_byte;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_bit == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/peri_uart_tx.sv
// Write-only UART transmit peripheral: data and control registers plus SEND handshake.
// Define PERI_UART_STATUS_EN to add the ctrl_o readback port (bit 0 = SEND / busy).
module peri_uart_tx
  import peri_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] data_i,
  input  logic        we_ctrl_uart_i,
  input  logic        we_data_uart_i,
`ifdef PERI_UART_STATUS_EN
  output logic [31:0] ctrl_o,
`endif
  output logic        uart_tx_o
);

  logic [DATA_BITS-1:0] r_data;
  logic                 r_send;
  logic                 w_set;
  logic                 w_done;
  logic                 w_unused_hi;

  assign w_set       = we_ctrl_uart_i & data_i[CTRL_SEND_BIT];
  assign w_unused_hi = ^data_i[31:DATA_BITS];

  // A set arriving in the DONE cycle wins over the clear, allowing a 2-cycle inter-frame gap.
  // Mid-frame sets are harmless since SEND is already 1 until DONE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_data <= '0;
      r_send <= 1'b0;
    end else begin
      if (we_data_uart_i) r_data <= data_i[DATA_BITS-1:0];
      if (w_set)          r_send <= 1'b1;
      else if (w_done)    r_send <= 1'b0;
    end
  end

`ifdef PERI_UART_STATUS_EN
  always_comb begin
    ctrl_o                = '0;
    ctrl_o[CTRL_SEND_BIT] = r_send;
  end
`endif

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_start (r_send),
    .i_byte  (r_data),
    .o_done  (w_done),
    .o_tx    (uart_tx_o)
  );

endmodule

// File: tb/tb_peri_uart_tx.sv
// Directed self-checking bench for peri_uart_tx; frames are checked cycle by cycle.
module tb_peri_uart_tx;

  localparam int unsigned C = 1042;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        we_ctrl_uart_i = 1'b0;
  logic        we_data_uart_i = 1'b0;
  logic        uart_tx_o;
  logic        send_obs;

  int checks = 0;
  int failures = 0;

`ifdef PERI_UART_STATUS_EN
  logic [31:0] ctrl_o;
  assign send_obs = ctrl_o[0];
`else
  assign send_obs = dut.r_send;
`endif

  peri_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .data_i         (data_i),
    .we_ctrl_uart_i (we_ctrl_uart_i),
    .we_data_uart_i (we_data_uart_i),
`ifdef PERI_UART_STATUS_EN
    .ctrl_o         (ctrl_o),
`endif
    .uart_tx_o      (uart_tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic bus_write(input logic wd, input logic wc, input logic [31:0] v);
    @(negedge clk_i);
    data_i = v;
    we_data_uart_i = wd;
    we_ctrl_uart_i = wc;
    @(negedge clk_i);
    we_data_uart_i = 1'b0;
    we_ctrl_uart_i = 1'b0;
    data_i = 32'hDEAD_BEEF;
  endtask

  task automatic wait_fall(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (uart_tx_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_start_timeout got=no_start_bit exp=start_within_100", name);
    end
  endtask

  // Entered at the first negedge of the start bit; ends at the negedge after DONE.
  task automatic check_frame(input logic [7:0] exp, input string name);
    int err[10];
    logic [7:0] rx;
    logic expbit;
    int b;
    rx = '0;
    for (int k = 0; k < 10; k++) err[k] = 0;
    for (int i = 0; i < 10 * C; i++) begin
      if (i > 0) @(negedge clk_i);
      b = i / C;
      expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp[b-1];
      if (uart_tx_o !== expbit) err[b]++;
      if ((i % C) == C / 2 && b >= 1 && b <= 8) rx[b-1] = uart_tx_o;
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (err[k] != 0) begin
        failures++;
        $display("FAIL %s_bit%0d got=%0d_bad_cycles exp=0", name, k, err[k]);
      end
    end
    checks++;
    if (rx !== exp) begin
      failures++;
      $display("FAIL %s_center_byte got=%02h exp=%02h", name, rx, exp);
    end
    @(negedge clk_i);
    checks++;
    if (uart_tx_o !== 1'b1 || send_obs !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_cycle got=tx%0b_send%0b exp=tx1_send1", name, uart_tx_o, send_obs);
    end
    @(negedge clk_i);
    checks++;
    if (send_obs !== 1'b0 || uart_tx_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_send_clear got=tx%0b_send%0b exp=tx1_send0", name, uart_tx_o, send_obs);
    end
  endtask

  task automatic watch_idle(input int n, input string name);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (uart_tx_o !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL %s got=%0d_low_cycles exp=0", name, lows);
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if (uart_tx_o !== 1'b1 || send_obs !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=tx%0b_send%0b exp=tx1_send0", uart_tx_o, send_obs);
    end
    reset_i = 1'b0;
    watch_idle(1000, "reset_idle");
  endtask

  task automatic test_basic;
    bus_write(1'b1, 1'b0, 32'h0000_0055);
    @(negedge clk_i);
    bus_write(1'b0, 1'b1, 32'h0000_0001);
    checks++;
    if (uart_tx_o !== 1'b1 || send_obs !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_write got=tx%0b_send%0b exp=tx1_send1", uart_tx_o, send_obs);
    end
    @(negedge clk_i);
    checks++;
    if (uart_tx_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_start_latency got=%0b exp=0", uart_tx_o);
    end
    check_frame(8'h55, "basic");
  endtask

  task automatic test_bus_width;
    bit ok;
    bus_write(1'b1, 1'b0, 32'hFFFF_FFA3);
    bus_write(1'b0, 1'b1, 32'h0000_0001);
    wait_fall("width", ok);
    if (ok) check_frame(8'hA3, "width");
  endtask

  task automatic test_busy;
    bit ok;
    bus_write(1'b1, 1'b0, 32'h0000_000F);
    bus_write(1'b0, 1'b1, 32'h0000_0001);
    wait_fall("busy", ok);
    if (ok) begin
      fork
        check_frame(8'h0F, "busy_frame");
        begin
          repeat (3 * C) @(negedge clk_i);
          data_i = 32'h0000_00F0;
          we_data_uart_i = 1'b1;
          we_ctrl_uart_i = 1'b1;
          @(negedge clk_i);
          we_data_uart_i = 1'b0;
          we_ctrl_uart_i = 1'b0;
        end
      join
      watch_idle(200, "busy_single_frame");
      bus_write(1'b0, 1'b1, 32'h0000_0001);
      wait_fall("busy_next", ok);
      if (ok) check_frame(8'hF0, "busy_next");
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    bus_write(1'b1, 1'b1, 32'h0000_0081);
    wait_fall("simul", ok);
    if (ok) check_frame(8'h81, "simul");
  endtask

  task automatic test_midframe_reset;
    bit ok;
    bus_write(1'b0, 1'b1, 32'h0000_0001);
    wait_fall("midrst", ok);
    if (ok) begin
      repeat (4 * C + C / 2) @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (uart_tx_o !== 1'b1 || send_obs !== 1'b0) begin
        failures++;
        $display("FAIL midrst_state got=tx%0b_send%0b exp=tx1_send0", uart_tx_o, send_obs);
      end
      reset_i = 1'b0;
      watch_idle(3 * C, "midrst_quiet");
    end
  endtask

  task automatic test_reset_clears_data;
    bit ok;
    bus_write(1'b0, 1'b1, 32'h0000_0001);
    wait_fall("rstdata", ok);
    if (ok) check_frame(8'h00, "rstdata");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bus_width();
    test_busy();
    test_simultaneous();
    test_midframe_reset();
    test_reset_clears_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
